fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  UART transmitter on the read side of the async FIFO, in the read clock domain.
//  Watches rempty, pops one word with a single-cycle rinc, latches rdata, and
//  serialises it as start / data LSB-first / [parity] / stop on txd.
//  Frames go back-to-back while the FIFO has data.
// PARAMETERS
//  DATA_WIDTH    8   data bits per frame; equals the FIFO data width
//  CLKS_PER_BIT  16  rclk cycles per serial bit; legal range >= 2
//  STOP_BITS     1   stop bits per frame; legal values 1 or 2
// PORTS
//  rclk     in   1           read-domain clock; all logic on posedge
//  rrst     in   1           asynchronous, active-high reset
//  rempty   in   1           FIFO empty flag; registered in the read domain
//  rdata    in   DATA_WIDTH  FIFO read data; valid whenever rempty=0
//  rinc     out  1           pop strobe; exactly one cycle per word
//  txd      out  1           serial output; idle level is 1
//  busy     out  1           1 while a frame is in progress (state != IDLE)
//  tx_done  out  1           one-cycle pulse in the final cycle of the last stop bit
// BEHAVIOUR
//  Reset: state=IDLE, txd=1, busy=0, tx_done=0, counters=0, shift register=0.
//   rinc=0 because state is IDLE and the pop condition is gated by reset.
//   Reset mid-frame forces txd=1 immediately and aborts the frame.
//   The popped word is lost; no re-read occurs.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//  Pop condition (combinational): rinc = ~rrst & ~rempty & (IDLE | (STOP & last_cycle)).
//   In the same edge: shreg <= rdata, baud_cnt <= 0, next state = START.
//  Bit timing: baud_cnt counts 0..CLKS_PER_BIT-1. A bit ends when baud_cnt == CLKS_PER_BIT-1.
//  START: txd=0 for CLKS_PER_BIT cycles, then enter DATA with bit_cnt=0.
//  DATA: txd=shreg[0]; at each bit end, shreg >>= 1 and bit_cnt++.
//   After bit DATA_WIDTH-1, go to PARITY if enabled, otherwise STOP.
//  STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done pulses in the last cycle.
//   Then go to START if rinc fires that cycle, otherwise IDLE.
//  txd is registered, so the start bit appears one cycle after the rinc cycle.
//   Frame period = (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, with P = 1 if parity is enabled.
//   Back-to-back frames have no idle gap.
//  rempty updates one cycle after rinc. The FSM never samples rempty outside
//   the pop condition, so a stale rempty cannot cause a double pop.
//  rdata is sampled only in the rinc cycle. Later changes to rdata do not affect the frame.
//  Counter widths: bit_cnt is $clog2(DATA_WIDTH+1) bits; baud_cnt is $clog2(CLKS_PER_BIT) bits.
//   The stop phase needs STOP_BITS*CLKS_PER_BIT cycles: either widen baud_cnt
//   by 1 bit or count stop bits with bit_cnt.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: a PARITY state follows DATA and lasts CLKS_PER_BIT cycles.
//   txd = ^latched_word (even parity), computed at latch time.
//  Not defined: no PARITY state; DATA goes straight to STOP; no parity logic is built.
// TESTING (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1)
//  Reset check: hold rrst=1 with rempty=0 -> txd=1, rinc=0, busy=0.
//   Release rrst -> rinc=1 in the first cycle.
//  Single frame: rempty=0, rdata=8'hA5, rempty rises after the pop.
//   -> exactly one rinc, then txd = 0,1,0,1,0,0,1,0,1,1 (each 4 cycles).
//   -> busy high for 40 cycles, tx_done one pulse, then IDLE.
//  Back-to-back: 3 words 8'h00, 8'hFF, 8'h55.
//   -> 3 rinc pulses, 40 cycles apart, and 120 contiguous frame cycles.
//   -> No idle cycle between frames.
//  Empty FIFO: rempty=1 for 200 cycles -> rinc=0, txd=1, busy=0 throughout.
//  Abort: assert rrst in cycle 10 of the DATA state -> txd=1 the same cycle.
//   -> After release with rempty=0, the next frame starts cleanly.
//  Parity (UART_TX_PARITY_EN): 8'h07 -> parity bit 1; 8'h03 -> parity bit 0.
//   -> Frame length 44 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining the read side of an async FIFO: pops one word per frame and
// shifts out start / data LSB-first / [even parity] / stop. Parity is built only with UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  stop_last;

  // bit_cnt doubles as the stop-bit counter so baud_cnt never needs widening.
  assign stop_last = (state_q == STOP) && (baud_q == BAUD_LAST) && (bit_q == STOP_LAST);
  assign rinc      = ~rrst & ~rempty & ((state_q == IDLE) | stop_last);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE:  baud_d = '0;
      START: if (baud_q == BAUD_LAST) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
      end
      DATA: if (baud_q == BAUD_LAST) begin
        baud_d  = '0;
        shreg_d = shreg_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_q == BAUD_LAST) begin
        state_d = STOP;
        baud_d  = '0;
        bit_d   = '0;
      end
`endif
      STOP: if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == STOP_LAST) begin
          state_d = IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    if (rinc) begin
      state_d  = START;
      baud_d   = '0;
      bit_d    = '0;
      shreg_d  = rdata;
`ifdef UART_TX_PARITY_EN
      parity_d = ^rdata;
`endif
    end

    // Outputs are registered from the next state so they line up with the state register.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1) with a queue
// standing in for the FIFO; rempty/rdata follow a pop one cycle after rinc.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11 * CPB;
`else
  localparam int F = 10 * CPB;
`endif

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc, txd, busy, tx_done;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] wq[$];
  logic [7:0] exp_w[$];
  logic txd_log[0:1023];
  logic busy_log[0:1023];
  logic done_log[0:1023];
  logic rinc_log[0:1023];

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_txd(input logic [7:0] w, input int idx);
    int b;
    b = idx / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] w, input bit expect_frame);
    wq.push_back(w);
    if (expect_frame) exp_w.push_back(w);
  endtask

  // Called #1 after a posedge: present the FIFO head to the DUT.
  task automatic present();
    rempty = (wq.size() == 0);
    rdata  = (wq.size() != 0) ? wq[0] : 8'h00;
  endtask

  // One clock: sample outputs mid-cycle, then apply the pop after the edge.
  task automatic step(input int c);
    logic popped;
    @(negedge rclk);
    txd_log[c]  = txd;
    busy_log[c] = busy;
    done_log[c] = tx_done;
    rinc_log[c] = rinc;
    popped      = rinc;
    @(posedge rclk);
    #1;
    if (popped && wq.size() != 0) void'(wq.pop_front());
    present();
  endtask

  task automatic run_frames(input string tag);
    int n, nc, cnt_rinc, cnt_done, cnt_busy;
    logic [7:0] w;
    n  = exp_w.size();
    nc = n * F + 5;
    for (int c = 0; c < nc; c++) step(c);
    cnt_rinc = 0; cnt_done = 0; cnt_busy = 0;
    for (int c = 0; c < nc; c++) begin
      cnt_rinc += int'(rinc_log[c]);
      cnt_done += int'(done_log[c]);
      if (c >= 1 && c <= n * F) cnt_busy += int'(busy_log[c]);
    end
    chk({tag, " rinc_count"}, cnt_rinc, n);
    chk({tag, " done_count"}, cnt_done, n);
    chk({tag, " busy_contig"}, cnt_busy, n * F);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s rinc_at_%0d", tag, i * F), rinc_log[i * F], 1);
      chk($sformatf("%s done_at_%0d", tag, (i + 1) * F), done_log[(i + 1) * F], 1);
    end
    for (int c = 1; c <= n * F; c++) begin
      w = exp_w[(c - 1) / F];
      chk($sformatf("%s txd_c%0d", tag, c), txd_log[c], exp_txd(w, (c - 1) % F));
    end
    chk({tag, " idle_busy"}, busy_log[n * F + 2], 0);
    chk({tag, " idle_txd"}, txd_log[n * F + 2], 1);
    exp_w.delete();
  endtask

  initial begin
    int bad_rinc, bad_txd, bad_busy;

    // Reset held with data available: nothing may pop.
    push(8'hA5, 1);
    present();
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("rst txd", txd, 1);
    chk("rst rinc", rinc, 0);
    chk("rst busy", busy, 0);
    chk("rst tx_done", tx_done, 0);
    @(posedge rclk);
    #1 rrst = 1'b0;
    run_frames("single_A5");

    // Back-to-back frames.
    @(posedge rclk); #1;
    push(8'h00, 1); push(8'hFF, 1); push(8'h55, 1);
    present();
    run_frames("b2b");

    // Empty FIFO.
    bad_rinc = 0; bad_txd = 0; bad_busy = 0;
    for (int c = 0; c < 200; c++) begin
      step(c);
      bad_rinc += int'(rinc_log[c]);
      bad_txd  += int'(!txd_log[c]);
      bad_busy += int'(busy_log[c]);
    end
    chk("empty rinc", bad_rinc, 0);
    chk("empty txd", bad_txd, 0);
    chk("empty busy", bad_busy, 0);

    // Abort in DATA cycle 10 (data bit 2 of 8'h00, txd low), then a clean frame.
    push(8'h00, 0); push(8'hC3, 1);
    present();
    for (int c = 0; c < 15; c++) step(c);
    chk("abort popped", rinc_log[0], 1);
    @(negedge rclk);
    chk("abort pre txd", txd, 0);
    chk("abort pre busy", busy, 1);
    #1 rrst = 1'b1;
    #1;
    chk("abort txd", txd, 1);
    chk("abort busy", busy, 0);
    chk("abort rinc", rinc, 0);
    repeat (2) @(posedge rclk);
    #1 rrst = 1'b0;
    run_frames("after_abort");

`ifdef UART_TX_PARITY_EN
    @(posedge rclk); #1;
    push(8'h07, 1); push(8'h03, 1);
    present();
    run_frames("parity");
    chk("parity 07", txd_log[1 + 9 * CPB], 1);
    chk("parity 03", txd_log[F + 1 + 9 * CPB], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
